mvm_param: RTL and testbench
============================

MVM_PARAM -- requirements
Module: mvm_param

Interface
REQ-001 Parameter K, default 8: matrix dimension (K x K matrix, K-element vector); K >= 2.
REQ-002 Parameter B, default 12: signed element width of A and x.
REQ-003 Parameter P, default 1: parallel MAC lanes; P SHALL divide K; illegal P is an elaboration error.
REQ-004 Parameter OW, default 2*B: signed result width.
REQ-005 Parameter SAT, default 0: 0 = results wrap to low OW bits; 1 = results saturate to the OW signed range.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 load_matrix  input  1  one-cycle pulse that opens a matrix load.
REQ-009 load_vector  input  1  one-cycle pulse that opens a vector load.
REQ-010 start  input  1  one-cycle pulse that requests a multiply.
REQ-011 in_valid  input  1  qualifies data_in during loads.
REQ-012 data_in  input  B  signed A or x element.
REQ-013 out_ready  input  1  downstream accepts data_out this cycle.
REQ-014 out_valid  output  1  data_out holds a valid y element.
REQ-015 data_out  output  OW  signed y element.
REQ-016 done  output  1  one-cycle pulse marking the end of compute.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-019 States: IDLE, LOAD_M, LOAD_V, COMPUTE, OUTPUT; only IDLE accepts commands. Commands in any other state are ignored and do not raise err.
REQ-020 In IDLE, priority is load_matrix > load_vector > start. Lower-priority commands asserted in the same cycle are dropped without err.
REQ-021 The pulse cycle itself captures no data. In LOAD_M, each cycle with in_valid=1 writes the next A element in row-major order (A[0][0], A[0][1], ...). In-valid gaps are allowed.
REQ-022 After the K*K-th element is written, the block returns to IDLE the next cycle and sets m_loaded=1. LOAD_V does the same for K elements and sets v_loaded=1.
REQ-023 m_loaded clears at load_matrix acceptance; v_loaded clears at load_vector acceptance. Stored A and x persist across runs, so a new vector can be multiplied by the retained matrix.
REQ-024 start with m_loaded=0 or v_loaded=0: err pulses one cycle and the state stays IDLE.
REQ-025 Accepted start enters COMPUTE, which lasts exactly K*K/P cycles. Each cycle accumulates P products A[r][c..c+P-1]*x[c..c+P-1] into row r. The accumulator is at least 2B+clog2(K) bits, so no internal overflow occurs.
REQ-026 At the end of each row, the full-precision sum is stored as y[r], reduced to OW per SAT.
- SAT=1: clamp to [-2^(OW-1), 2^(OW-1)-1].
- SAT=0: keep the low OW bits.
REQ-027 The first OUTPUT cycle follows the last COMPUTE cycle; done=1 on that cycle only.
REQ-028 In OUTPUT, out_valid=1 and data_out=y[i], starting at i=0. The index advances on each cycle with out_ready=1. While out_ready=0, data_out holds stable.
REQ-029 After y[K-1] is accepted, out_valid drops and the state returns to IDLE the next cycle. Loaded flags are unchanged.
REQ-030 Outside OUTPUT: out_valid=0 and data_out=0.

Reset
REQ-031 reset=0 at any time, including mid-load, mid-compute or mid-output, forces IDLE immediately.
REQ-032 On reset: m_loaded=0, v_loaded=0, all counters cleared; out_valid, data_out, done, busy, err all 0.
REQ-033 Storage contents after reset are don't-care; they are never observable without reloading, because start is rejected until both flags are set.

Verification
REQ-034 K=8, B=12, P=1: load identity A and x=1..8, then start -> done exactly 64 cycles after the start cycle; y=1..8 on 8 consecutive cycles with out_ready=1.
REQ-035 All A and x = -2048 (each product 4194304, row sum 33554432) -> SAT=1 gives y=8388607 for every row; SAT=0 gives y=0 for every row.
REQ-036 Backpressure: drop out_ready for 3 cycles while y[2] is presented -> data_out stays y[2] and out_valid stays 1; y[3] follows once out_ready returns.
REQ-037 Rejection and reuse:
- start after reset with no loads -> err pulses for 1 cycle, busy stays 0.
- load only a new x, then start -> results use the retained A.
REQ-038 Reset asserted 10 cycles into COMPUTE -> IDLE with all outputs 0; the next start gives err=1 until both A and x are reloaded.
REQ-039 P=4, K=8: same stimulus as REQ-034 -> done 16 cycles after start, identical y.

Source files
------------

// File: rtl/mvm_param.sv
// Parameterised K x K signed matrix-vector multiplier with P parallel MAC lanes.
// A and x are loaded element-serially and retained; results stream out under out_ready backpressure.
module mvm_param #(
  parameter int K   = 8,
  parameter int B   = 12,
  parameter int P   = 1,
  parameter int OW  = 2*B,
  parameter int SAT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_matrix,
  input  logic                 load_vector,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [B-1:0]  data_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [OW-1:0] data_out,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int KK  = K*K;
  localparam int RW  = (K > 1) ? $clog2(K) : 1;
  localparam int MW  = $clog2(KK);
  localparam int AW0 = 2*B + $clog2(K) + 1;
  localparam int AW  = (AW0 > OW) ? AW0 : OW + 1;

  localparam logic signed [AW-1:0] YMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  if ((P < 1) || (K < 2) || ((K % P) != 0)) begin : g_param_check
    $error("mvm_param: K must be >= 2 and P must divide K");
  end

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, OUTPUT} state_t;

  state_t state;
  logic   m_loaded, v_loaded;

  logic signed [B-1:0]  amem [KK];
  logic signed [B-1:0]  xmem [K];
  logic signed [OW-1:0] ymem [K];

  logic [MW-1:0]        ld_cnt;
  logic [RW-1:0]        row, col, oidx;
  logic signed [AW-1:0] acc, row_sum;
  logic signed [OW-1:0] y_red;
  logic                 row_end, last_row, ld_last_m, ld_last_v;

  logic signed [2*B-1:0] prod [P];
  logic signed [AW-1:0]  part [P+1];

  assign part[0] = '0;

  for (genvar p = 0; p < P; p++) begin : g_lane
    logic [RW-1:0] ci;
    logic [MW-1:0] ai;
    assign ci          = col + RW'(p);
    assign ai          = MW'(row) * MW'(K) + MW'(ci);
    assign prod[p]     = amem[ai] * xmem[ci];
    assign part[p+1]   = part[p] + AW'(prod[p]);
  end

  assign row_sum   = acc + part[P];
  assign row_end   = (col == RW'(K-P));
  assign last_row  = (row == RW'(K-1));
  assign ld_last_m = (ld_cnt == MW'(KK-1));
  assign ld_last_v = (ld_cnt == MW'(K-1));
  assign busy      = (state != IDLE);

  // Accumulator is wide enough for a full row, so only the final store narrows.
  always_comb begin
    y_red = row_sum[OW-1:0];
    if (SAT != 0) begin
      if (row_sum > YMAX)      y_red = YMAX[OW-1:0];
      else if (row_sum < YMIN) y_red = YMIN[OW-1:0];
    end
  end

  // Storage needs no reset: start is refused until both operands are reloaded.
  always_ff @(posedge clk) begin
    if (state == LOAD_M && in_valid) amem[ld_cnt]      <= data_in;
    if (state == LOAD_V && in_valid) xmem[RW'(ld_cnt)] <= data_in;
    if (state == COMPUTE && row_end) ymem[row]         <= y_red;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      m_loaded  <= 1'b0;
      v_loaded  <= 1'b0;
      ld_cnt    <= '0;
      row       <= '0;
      col       <= '0;
      oidx      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_matrix) begin
            state    <= LOAD_M;
            m_loaded <= 1'b0;
            ld_cnt   <= '0;
          end else if (load_vector) begin
            state    <= LOAD_V;
            v_loaded <= 1'b0;
            ld_cnt   <= '0;
          end else if (start) begin
            if (m_loaded && v_loaded) begin
              state <= COMPUTE;
              row   <= '0;
              col   <= '0;
              acc   <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD_M: begin
          if (in_valid) begin
            if (ld_last_m) begin
              state    <= IDLE;
              m_loaded <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        LOAD_V: begin
          if (in_valid) begin
            if (ld_last_v) begin
              state    <= IDLE;
              v_loaded <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (row_end) begin
            acc <= '0;
            col <= '0;
            if (last_row) begin
              // y[0] was stored rows ago, so it can be presented on the first OUTPUT cycle.
              state     <= OUTPUT;
              done      <= 1'b1;
              out_valid <= 1'b1;
              data_out  <= ymem[0];
              oidx      <= '0;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= row_sum;
            col <= col + RW'(P);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (oidx == RW'(K-1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              data_out  <= '0;
            end else begin
              oidx     <= oidx + 1'b1;
              data_out <= ymem[oidx + 1'b1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_param.sv
// Randomised bench for mvm_param: two instances (P=1/SAT=1 and P=4/SAT=0) share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_mvm_param;

  localparam int K  = 8;
  localparam int B  = 12;
  localparam int OW = 24;
  localparam int KK = K*K;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [B-1:0] data_in = '0;

  logic ov [2];
  logic dn [2];
  logic bz [2];
  logic er [2];
  logic signed [OW-1:0] dout [2];

  always #5 clk = ~clk;

  mvm_param #(.K(K), .B(B), .P(1), .OW(OW), .SAT(1)) u_dut0 (
    .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
    .start(start), .in_valid(in_valid), .data_in(data_in), .out_ready(out_ready),
    .out_valid(ov[0]), .data_out(dout[0]), .done(dn[0]), .busy(bz[0]), .err(er[0])
  );

  mvm_param #(.K(K), .B(B), .P(4), .OW(OW), .SAT(0)) u_dut1 (
    .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
    .start(start), .in_valid(in_valid), .data_in(data_in), .out_ready(out_ready),
    .out_valid(ov[1]), .data_out(dout[1]), .done(dn[1]), .busy(bz[1]), .err(er[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: 0 idle, 1 load A, 2 load x, 3 compute, 4 output
  int     ms [2];
  int     cnt [2];
  int     oi [2];
  bit     mload [2];
  bit     vload [2];
  bit     eerr [2];
  bit     edone [2];
  int     am [2][KK];
  int     xm [2][K];
  longint ey [2][K];

  int done_at [2];
  int er_cnt [2];

  logic signed [B-1:0] abuf [KK];
  logic signed [B-1:0] xbuf [K];

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  function automatic longint reduce(input longint f, input bit sat);
    longint hi, lo, m;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -hi - 1;
    if (sat) return (f > hi) ? hi : ((f < lo) ? lo : f);
    m = f & ((longint'(1) <<< OW) - 1);
    if (m > hi) m = m - (longint'(1) <<< OW);
    return m;
  endfunction

  initial begin : model
    longint s;
    forever begin
      @(posedge clk or negedge reset);
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          ms[d] = 0; cnt[d] = 0; oi[d] = 0;
          mload[d] = 1'b0; vload[d] = 1'b0; eerr[d] = 1'b0; edone[d] = 1'b0;
        end else begin
          eerr[d]  = 1'b0;
          edone[d] = 1'b0;
          case (ms[d])
            0: begin
              if (load_matrix) begin
                ms[d] = 1; mload[d] = 1'b0; cnt[d] = 0;
              end else if (load_vector) begin
                ms[d] = 2; vload[d] = 1'b0; cnt[d] = 0;
              end else if (start) begin
                if (mload[d] && vload[d]) begin
                  ms[d] = 3; cnt[d] = 0;
                  for (int r = 0; r < K; r++) begin
                    s = 0;
                    for (int c = 0; c < K; c++) s += longint'(am[d][r*K+c]) * longint'(xm[d][c]);
                    ey[d][r] = reduce(s, d == 0);
                  end
                end else begin
                  eerr[d] = 1'b1;
                end
              end
            end
            1: if (in_valid) begin
              am[d][cnt[d]] = data_in;
              cnt[d]++;
              if (cnt[d] == KK) begin ms[d] = 0; mload[d] = 1'b1; end
            end
            2: if (in_valid) begin
              xm[d][cnt[d]] = data_in;
              cnt[d]++;
              if (cnt[d] == K) begin ms[d] = 0; vload[d] = 1'b1; end
            end
            3: begin
              cnt[d]++;
              if (cnt[d] == KK / ((d == 0) ? 1 : 4)) begin
                ms[d] = 4; edone[d] = 1'b1; oi[d] = 0;
              end
            end
            default: if (out_ready) begin
              if (oi[d] == K-1) ms[d] = 0;
              else oi[d]++;
            end
          endcase
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, bz[d], ms[d] != 0);
        chk("out_valid", d, ov[d], ms[d] == 4);
        chk("data_out", d, dout[d], (ms[d] == 4) ? ey[d][oi[d]] : 0);
        chk("done", d, dn[d], edone[d]);
        chk("err", d, er[d], eerr[d]);
        if (dn[d] && done_at[d] < 0) done_at[d] = cyc;
        if (er[d]) er_cnt[d]++;
      end
    end
  end

  task automatic clear_cmds();
    load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic load_m(input bit prio);
    int idx;
    @(negedge clk);
    load_matrix = 1'b1;
    if (prio) begin load_vector = 1'b1; start = 1'b1; end
    @(negedge clk);
    clear_cmds();
    idx = 0;
    while (idx < KK) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; data_in = B'($urandom);
      end else begin
        in_valid = 1'b1; data_in = abuf[idx]; idx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic load_v();
    int idx;
    @(negedge clk);
    load_vector = 1'b1;
    @(negedge clk);
    load_vector = 1'b0;
    idx = 0;
    while (idx < K) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; data_in = B'($urandom);
      end else begin
        in_valid = 1'b1; data_in = xbuf[idx]; idx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic start_reject();
    int e0 [2];
    for (int d = 0; d < 2; d++) e0[d] = er_cnt[d];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reject_err_pulses", d, er_cnt[d] - e0[d], 1);
      chk("reject_busy", d, bz[d], 0);
    end
  endtask

  // mode: 0 ready always, 1 random ready, 2 backpressure on y[2], 3 random ready + ignored commands
  // pin: 1 identity/1..8 expectations, 2 all -2048 expectations
  task automatic run(input int mode, input int pin);
    int s, budget, bp, stall;
    done_at[0] = -1; done_at[1] = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 s = cyc;
    for (int r = 0; r < K; r++) begin
      if (pin == 1) begin
        chk("pin_ident_y", 0, ey[0][r], r + 1);
        chk("pin_ident_y", 1, ey[1][r], r + 1);
      end else if (pin == 2) begin
        chk("pin_sat_y", 0, ey[0][r], 8388607);
        chk("pin_wrap_y", 1, ey[1][r], 0);
      end
    end
    @(negedge clk); start = 1'b0;
    budget = 0; bp = 0; stall = 0;
    while ((bz[0] || bz[1]) && budget < 1000) begin
      case (mode)
        2: begin
          if (bp == 0 && ov[0] && dout[0] == 3) begin
            out_ready = 1'b0; stall = 3; bp = 1;
          end else if (bp == 1) begin
            chk("bp_hold_data", 0, dout[0], 3);
            chk("bp_hold_valid", 0, ov[0], 1);
            stall--;
            if (stall == 0) begin out_ready = 1'b1; bp = 2; end
          end else if (bp == 2) begin
            chk("bp_next_data", 0, dout[0], 4);
            chk("bp_next_valid", 0, ov[0], 1);
            bp = 3;
          end
        end
        1, 3: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
      if (mode == 3 && bz[0] && bz[1]) begin
        load_matrix = ($urandom_range(0, 5) == 0);
        load_vector = ($urandom_range(0, 5) == 0);
        start       = ($urandom_range(0, 5) == 0);
        in_valid    = $urandom_range(0, 1) != 0;
        data_in     = B'($urandom);
      end else begin
        clear_cmds();
      end
      @(negedge clk);
      budget++;
    end
    clear_cmds();
    out_ready = 1'b1;
    chk("run_completes", 0, budget < 1000, 1);
    if (mode == 2) chk("bp_seen", 0, bp, 3);
    if (pin == 1) begin
      chk("done_latency", 0, done_at[0] - s, 64);
      chk("done_latency", 1, done_at[1] - s, 16);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    done_at[0] = -1; done_at[1] = -1;
    er_cnt[0] = 0; er_cnt[1] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Start with nothing loaded is rejected
    start_reject();

    // Identity matrix, x = 1..8
    for (int i = 0; i < KK; i++) abuf[i] = ((i / K) == (i % K)) ? B'(1) : '0;
    for (int c = 0; c < K; c++) xbuf[c] = B'(c + 1);
    load_m(1'b0);
    load_v();
    run(0, 1);

    // Same operands retained, downstream stalls on y[2]
    run(2, 1);

    // Extreme operands: saturate vs wrap; load with simultaneous lower-priority commands
    for (int i = 0; i < KK; i++) abuf[i] = B'(-2048);
    for (int c = 0; c < K; c++) xbuf[c] = B'(-2048);
    load_m(1'b1);
    load_v();
    run(1, 2);

    // Random operands, then a fresh vector against the retained matrix
    for (int i = 0; i < KK; i++) abuf[i] = B'($urandom);
    for (int c = 0; c < K; c++) xbuf[c] = B'($urandom);
    load_m(1'b0);
    load_v();
    run(1, 0);
    for (int c = 0; c < K; c++) xbuf[c] = B'($urandom);
    load_v();
    run(1, 0);

    // Reset in the middle of compute
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, ov[d], 0);
      chk("rst_data_out", d, dout[d], 0);
      chk("rst_busy", d, bz[d], 0);
      chk("rst_done", d, dn[d], 0);
      chk("rst_err", d, er[d], 0);
    end
    @(negedge clk);
    reset = 1'b1;
    start_reject();
    load_v();
    start_reject();
    load_m(1'b0);
    run(0, 0);

    // Random rounds with commands that must be ignored while busy
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < KK; i++) abuf[i] = B'($urandom);
      for (int c = 0; c < K; c++) xbuf[c] = B'($urandom);
      load_m(1'($urandom_range(0, 1)));
      load_v();
      run(3, 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
